// File: rtl/control_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_pipe
//  Description : Registered RV32 decode/control stage between fetch and
//                execute. Accepts one instruction per in_valid/in_ready
//                handshake, decodes type flags, access size, immediate
//                format and register fields, and presents them from an
//                output register. M-extension ops occupy the stage for
//                MUL_CYCLES / DIV_CYCLES cycles so execute sees a stall.
//                Supports a synchronous flush, rd==x0 write suppression
//                and a busy indication while an M-op occupies the stage.
//  Optional    : define CU_ILLEGAL_DETECT_EN to add the 'illegal' output
//                (unknown opcode or unsupported R-type funct7).
//  Ports       : clk, rst_n (async, active low), flush
//                in_valid / in_ready / instr      - fetch side
//                out_valid / out_ready            - execute side
//                busy                             - M-op occupancy
//                reg_write, r_type, i_type, sb_type, uj_type, s_type,
//                load_type, lui, auipc, m_type, m_div - decode flags
//                size, imm_sel, rd, rs1, rs2, funct3  - decode fields
//                illegal (CU_ILLEGAL_DETECT_EN only)
//  Revision    : 1.0 - initial registered, parametrised release
// ============================================================================
module control_unit_pipe #(
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        reg_write,
  output logic        r_type,
  output logic        i_type,
  output logic        sb_type,
  output logic        uj_type,
  output logic        s_type,
  output logic        load_type,
  output logic        lui,
  output logic        auipc,
  output logic        m_type,
  output logic        m_div,
  output logic [1:0]  size,
  output logic [2:0]  imm_sel,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3
`ifdef CU_ILLEGAL_DETECT_EN
  ,
  output logic        illegal
`endif
);

  // Counter is wide enough for whichever occupancy is larger, so an
  // unusual MUL_CYCLES > DIV_CYCLES setting still loads correctly.
  localparam int c_MUL_W = $clog2(MUL_CYCLES + 1);
  localparam int c_CW    = (CNT_W > c_MUL_W) ? CNT_W : c_MUL_W;

  localparam logic [c_CW-1:0] c_MUL_LOAD = c_CW'(MUL_CYCLES - 1);
  localparam logic [c_CW-1:0] c_DIV_LOAD = c_CW'(DIV_CYCLES - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [c_CW-1:0] c_CNT_ZERO = '0;
  localparam logic            c_MUL_LONG = (MUL_CYCLES > 1);
  localparam logic            c_DIV_LONG = (DIV_CYCLES > 1);

  localparam logic [6:0] c_OP_R     = 7'b0110011;
  localparam logic [6:0] c_OP_I     = 7'b0010011;
  localparam logic [6:0] c_OP_SB    = 7'b1100011;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;
  localparam logic [6:0] c_OP_S     = 7'b0100011;
  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // --------------------------------------------------------------------------
  logic [6:0] w_opcode;
  logic [6:0] w_funct7;
  logic [2:0] w_funct3;
  logic       w_r, w_i, w_sb, w_uj, w_s, w_load, w_lui, w_auipc;
  logic       w_m, w_mdiv, w_reg_write;
  logic [1:0] w_size;
  logic [2:0] w_imm_sel;
  logic       w_long;
  logic [c_CW-1:0] w_load_val;
  logic       w_accept;

  assign w_opcode = instr[6:0];
  assign w_funct7 = instr[31:25];
  assign w_funct3 = instr[14:12];

  assign w_r     = (w_opcode == c_OP_R);
  assign w_i     = (w_opcode == c_OP_I);
  assign w_sb    = (w_opcode == c_OP_SB);
  assign w_uj    = (w_opcode == c_OP_JAL) | (w_opcode == c_OP_JALR);
  assign w_s     = (w_opcode == c_OP_S);
  assign w_load  = (w_opcode == c_OP_LOAD);
  assign w_lui   = (w_opcode == c_OP_LUI);
  assign w_auipc = (w_opcode == c_OP_AUIPC);

`ifdef CU_ILLEGAL_DETECT_EN
  logic w_known;
  logic w_bad_f7;
  logic w_illegal;
  assign w_known   = w_r | w_i | w_sb | w_uj | w_s | w_load | w_lui | w_auipc;
  assign w_bad_f7  = w_r & ~((w_funct7 == 7'b0000000) |
                             (w_funct7 == 7'b0100000) |
                             (w_funct7 == 7'b0000001));
  assign w_illegal = ~w_known | w_bad_f7;
  // An illegal word never writes back and never enters the M-op wait.
  assign w_m         = w_r & (w_funct7 == 7'b0000001) & ~w_illegal;
  assign w_reg_write = (w_r | w_i | w_load | w_auipc | w_lui | w_uj) &
                       (instr[11:7] != 5'd0) & ~w_illegal;
`else
  assign w_m         = w_r & (w_funct7 == 7'b0000001);
  assign w_reg_write = (w_r | w_i | w_load | w_auipc | w_lui | w_uj) &
                       (instr[11:7] != 5'd0);
`endif

  assign w_mdiv = w_m & w_funct3[2];

  always_comb begin
    w_size = 2'd0;
    case (w_funct3)
      3'b000, 3'b100: w_size = 2'd1;
      3'b001, 3'b101: w_size = 2'd2;
      3'b010:         w_size = 2'd3;
      default:        w_size = 2'd0;
    endcase
  end

  always_comb begin
    w_imm_sel = 3'd5;
    if (w_i | w_load)         w_imm_sel = 3'd0;
    else if (w_sb)            w_imm_sel = 3'd1;
    else if (w_lui | w_auipc) w_imm_sel = 3'd2;
    else if (w_uj)            w_imm_sel = 3'd3;
    else if (w_s)             w_imm_sel = 3'd4;
    else                      w_imm_sel = 3'd5;
  end

  assign w_long     = w_m & (w_mdiv ? c_DIV_LONG : c_MUL_LONG);
  assign w_load_val = w_mdiv ? c_DIV_LOAD : c_MUL_LOAD;

  // --------------------------------------------------------------------------
  // Handshake / occupancy FSM with registered bundle
  // --------------------------------------------------------------------------
  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic            r_out_valid, r_busy;
  logic            r_reg_write, r_r, r_i, r_sb, r_uj, r_s, r_load;
  logic            r_lui, r_auipc, r_m, r_mdiv;
  logic [1:0]      r_size;
  logic [2:0]      r_imm_sel, r_funct3;
  logic [4:0]      r_rd, r_rs1, r_rs2;
`ifdef CU_ILLEGAL_DETECT_EN
  logic            r_illegal;
`endif

  // in_ready stays a function of the handshake even under flush; flush
  // only discards the word.
  assign in_ready = (r_state == S_IDLE) | ((r_state == S_VALID) & out_ready);
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= c_CNT_ZERO;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_reg_write <= 1'b0;
      r_r         <= 1'b0;
      r_i         <= 1'b0;
      r_sb        <= 1'b0;
      r_uj        <= 1'b0;
      r_s         <= 1'b0;
      r_load      <= 1'b0;
      r_lui       <= 1'b0;
      r_auipc     <= 1'b0;
      r_m         <= 1'b0;
      r_mdiv      <= 1'b0;
      r_size      <= 2'd0;
      r_imm_sel   <= 3'd0;
      r_funct3    <= 3'd0;
      r_rd        <= 5'd0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
`ifdef CU_ILLEGAL_DETECT_EN
      r_illegal   <= 1'b0;
`endif
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= c_CNT_ZERO;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_accept) begin
      r_reg_write <= w_reg_write;
      r_r         <= w_r;
      r_i         <= w_i;
      r_sb        <= w_sb;
      r_uj        <= w_uj;
      r_s         <= w_s;
      r_load      <= w_load;
      r_lui       <= w_lui;
      r_auipc     <= w_auipc;
      r_m         <= w_m;
      r_mdiv      <= w_mdiv;
      r_size      <= w_size;
      r_imm_sel   <= w_imm_sel;
      r_funct3    <= w_funct3;
      r_rd        <= instr[11:7];
      r_rs1       <= instr[19:15];
      r_rs2       <= instr[24:20];
`ifdef CU_ILLEGAL_DETECT_EN
      r_illegal   <= w_illegal;
`endif
      if (w_long) begin
        // Loading L-1 and leaving WAIT at count 1 makes out_valid rise
        // exactly L cycles after the accept cycle.
        r_state     <= S_WAIT;
        r_cnt       <= w_load_val;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b1;
      end else begin
        r_state     <= S_VALID;
        r_cnt       <= c_CNT_ZERO;
        r_out_valid <= 1'b1;
        r_busy      <= 1'b0;
      end
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == c_CNT_ONE) begin
            r_state     <= S_VALID;
            r_cnt       <= c_CNT_ZERO;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        S_VALID: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        S_IDLE: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= c_CNT_ZERO;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign reg_write = r_reg_write;
  assign r_type    = r_r;
  assign i_type    = r_i;
  assign sb_type   = r_sb;
  assign uj_type   = r_uj;
  assign s_type    = r_s;
  assign load_type = r_load;
  assign lui       = r_lui;
  assign auipc     = r_auipc;
  assign m_type    = r_m;
  assign m_div     = r_mdiv;
  assign size      = r_size;
  assign imm_sel   = r_imm_sel;
  assign funct3    = r_funct3;
  assign rd        = r_rd;
  assign rs1       = r_rs1;
  assign rs2       = r_rs2;
`ifdef CU_ILLEGAL_DETECT_EN
  assign illegal   = r_illegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_control_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit_pipe
//  Description : Directed, table-driven bench for control_unit_pipe with
//                hand-written sequences for M-op occupancy, back-pressure,
//                flush and asynchronous reset. Honours CU_ILLEGAL_DETECT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        in_ready, out_valid, busy;
  logic        reg_write, r_type, i_type, sb_type, uj_type, s_type;
  logic        load_type, lui, auipc, m_type, m_div;
  logic [1:0]  size;
  logic [2:0]  imm_sel, funct3;
  logic [4:0]  rd, rs1, rs2;
`ifdef CU_ILLEGAL_DETECT_EN
  logic        illegal;
`endif

  control_unit_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .reg_write(reg_write), .r_type(r_type), .i_type(i_type),
    .sb_type(sb_type), .uj_type(uj_type), .s_type(s_type),
    .load_type(load_type), .lui(lui), .auipc(auipc),
    .m_type(m_type), .m_div(m_div), .size(size), .imm_sel(imm_sel),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3)
`ifdef CU_ILLEGAL_DETECT_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  // Flag order: {reg_write, r, i, sb, uj, s, load, lui, auipc, m, m_div}
  logic [10:0] act_flags;
  // Field order: {size, imm_sel, rd, rs1, rs2, funct3}
  logic [22:0] act_fields;
  assign act_flags  = {reg_write, r_type, i_type, sb_type, uj_type, s_type,
                       load_type, lui, auipc, m_type, m_div};
  assign act_fields = {size, imm_sel, rd, rs1, rs2, funct3};

  typedef struct {
    logic [31:0] instr;
    logic [10:0] flags;
    logic [22:0] fields;
    logic        ill;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  int n_vec  = 0;
  int n_fail = 0;

  function automatic logic [22:0] fld(input int sz, input int im, input int d,
                                      input int s1, input int s2, input int f3);
    return {2'(sz), 3'(im), 5'(d), 5'(s1), 5'(s2), 3'(f3)};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"},  32'(out_valid), 32'd0);
    check({name, "_busy"},   32'(busy), 32'd0);
    check({name, "_ready"},  32'(in_ready), 32'd1);
    check({name, "_flags"},  32'(act_flags), 32'd0);
    check({name, "_fields"}, 32'(act_fields), 32'd0);
  endtask

  localparam logic [31:0] DIV_X5 = 32'h027342B3;
  localparam logic [31:0] ADD_X3 = 32'h002081B3;
  localparam logic [10:0] DIV_FLAGS = 11'b1_1_0_0_0_0_0_0_0_1_1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h002081B3, 11'b1_1_0_0_0_0_0_0_0_0_0, fld(1,5,3,1,2,0),  1'b0}; // add x3,x1,x2
    vecs[1]  = '{32'h00812203, 11'b1_0_0_0_0_0_1_0_0_0_0, fld(3,0,4,2,8,2),  1'b0}; // lw x4,8(x2)
    vecs[2]  = '{32'h00000013, 11'b0_0_1_0_0_0_0_0_0_0_0, fld(1,0,0,0,0,0),  1'b0}; // addi x0,x0,0
    vecs[3]  = '{32'h027302B3, 11'b1_1_0_0_0_0_0_0_0_1_0, fld(1,5,5,6,7,0),  1'b0}; // mul x5,x6,x7
    vecs[4]  = '{32'h00512623, 11'b0_0_0_0_0_1_0_0_0_0_0, fld(3,4,12,2,5,2), 1'b0}; // sw x5,12(x2)
    vecs[5]  = '{32'h00208063, 11'b0_0_0_1_0_0_0_0_0_0_0, fld(1,1,0,1,2,0),  1'b0}; // beq x1,x2,0
    vecs[6]  = '{32'h123453B7, 11'b1_0_0_0_0_0_0_1_0_0_0, fld(2,2,7,8,3,5),  1'b0}; // lui x7,0x12345
    vecs[7]  = '{32'h00000097, 11'b1_0_0_0_0_0_0_0_1_0_0, fld(1,2,1,0,0,0),  1'b0}; // auipc x1,0
    vecs[8]  = '{32'h000000EF, 11'b1_0_0_0_1_0_0_0_0_0_0, fld(1,3,1,0,0,0),  1'b0}; // jal x1,0
    vecs[9]  = '{32'h00008067, 11'b0_0_0_0_1_0_0_0_0_0_0, fld(1,3,0,1,0,0),  1'b0}; // jalr x0,0(x1)
    vecs[10] = '{32'h0000007F, 11'b0_0_0_0_0_0_0_0_0_0_0, fld(1,5,0,0,0,0),  1'b1}; // unknown opcode
    vecs[11] = '{32'h00001403, 11'b1_0_0_0_0_0_1_0_0_0_0, fld(2,0,8,0,0,1),  1'b0}; // lh x8,0(x0)
    vecs[12] = '{32'h0000B093, 11'b1_0_1_0_0_0_0_0_0_0_0, fld(0,0,1,1,0,3),  1'b0}; // sltiu x1,x1,0

    // ---------------- reset state ----------------
    @(negedge clk);
    check_all_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // ---------------- table: back-to-back, one beat per cycle ----------------
    instr = vecs[0].instr;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      check("tbl_valid",  32'(out_valid),  32'd1);
      check("tbl_flags",  32'(act_flags),  32'(vecs[i].flags));
      check("tbl_fields", 32'(act_fields), 32'(vecs[i].fields));
      check("tbl_ready",  32'(in_ready),   32'd1);
`ifdef CU_ILLEGAL_DETECT_EN
      check("tbl_illegal", 32'(illegal), 32'(vecs[i].ill));
`endif
      if (i + 1 < NV) instr = vecs[i+1].instr;
      else            in_valid = 1'b0;
    end
    @(negedge clk);
    check("tbl_drain_valid", 32'(out_valid), 32'd0);
    check("tbl_drain_ready", 32'(in_ready),  32'd1);

    // ---------------- div: 32-cycle occupancy ----------------
    instr = DIV_X5;
    in_valid = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("div_wait_valid", 32'(out_valid), 32'd0);
      check("div_wait_busy",  32'(busy),      32'd1);
      check("div_wait_ready", 32'(in_ready),  32'd0);
    end
    @(negedge clk);
    check("div_valid",  32'(out_valid),  32'd1);
    check("div_busy",   32'(busy),       32'd0);
    check("div_flags",  32'(act_flags),  32'(DIV_FLAGS));
    check("div_fields", 32'(act_fields), 32'(fld(1,5,5,6,7,4)));

    // ---------------- back-pressure: hold 5 cycles ----------------
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = ADD_X3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid",  32'(out_valid),  32'd1);
      check("hold_ready",  32'(in_ready),   32'd0);
      check("hold_flags",  32'(act_flags),  32'(DIV_FLAGS));
      check("hold_fields", 32'(act_fields), 32'(fld(1,5,5,6,7,4)));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready),  32'd1);

    // ---------------- flush 10 cycles into a div wait ----------------
    instr = DIV_X5;
    in_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    check("flush_pre_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    in_valid = 1'b1;
    instr = ADD_X3;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_busy",  32'(busy),      32'd0);
    check("flush_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    check("flush_idle_valid", 32'(out_valid), 32'd0);

    // flush beats a same-cycle accept in IDLE
    flush = 1'b1;
    in_valid = 1'b1;
    instr = ADD_X3;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_acc_valid", 32'(out_valid), 32'd0);
    check("flush_acc_rd",    32'(rd),        32'd5);
    @(negedge clk);
    check("flush_acc_valid2", 32'(out_valid), 32'd0);

    // ---------------- async reset mid-WAIT ----------------
    instr = DIV_X5;
    in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    check("rst_pre_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_rst");

`ifdef CU_ILLEGAL_DETECT_EN
    // ---------------- illegal R-type funct7 ----------------
    instr = 32'h040001B3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("ill_f7_valid",     32'(out_valid), 32'd1);
    check("ill_f7_illegal",   32'(illegal),   32'd1);
    check("ill_f7_reg_write", 32'(reg_write), 32'd0);
    check("ill_f7_m_type",    32'(m_type),    32'd0);
    check("ill_f7_rd",        32'(rd),        32'd3);
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_unit_pipe.md
Name: control_unit_pipe

Overview:
Registered, parametrised successor to the combinational RV32 decode/control unit. It sits between fetch and execute: it accepts one 32-bit instruction per valid/ready handshake, decodes the type flags, access size and immediate select, and presents them from an output register. M-extension ops hold the stage for a configurable occupancy so execute sees a multi-cycle mul/div as a stall. It adds flush, rd==x0 write suppression and a busy indication.

Parameters:
MUL_CYCLES, 1, cycles an M-type multiply (funct3[2]=0) occupies the stage; legal range >=1
DIV_CYCLES, 32, cycles an M-type div/rem (funct3[2]=1) occupies the stage; legal range >=1
CNT_W, $clog2(DIV_CYCLES+1), occupancy counter width; derived, not overridden

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush
in_valid  in  1  fetch has an instruction
in_ready  out  1  stage can accept this cycle
instr  in  32  instruction word
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute consumes the bundle
busy  out  1  M-op occupancy in progress
reg_write, r_type, i_type, sb_type, uj_type, s_type, load_type, lui, auipc, m_type, m_div  out  1 each  registered decode flags
size  out  2  access size
imm_sel  out  3  immediate format
rd, rs1, rs2  out  5 each  register fields
funct3  out  3  passthrough
illegal  out  1  only with CU_ILLEGAL_DETECT_EN

Behaviour:
- Reset (async, rst_n=0): state IDLE; every registered output 0; counter 0. in_ready=1 after reset.
- Decode by opcode instr[6:0]: R 0110011, I 0010011, SB 1100011, UJ 1101111 or 1100111, S 0100011, load 0000011, LUI 0110111, AUIPC 0010111.
- m_type = R & (funct7==0000001). Non-R instructions never set m_type. m_div = m_type & funct3[2].
- reg_write = (R|I|load|AUIPC|LUI|UJ) & (rd != 0).
- size from funct3: 000/100->1, 001/101->2, 010->3, else 0.
- imm_sel priority: I or load->0, SB->1, LUI/AUIPC->2, UJ->3, S->4, otherwise->5.
- States: IDLE, WAIT, VALID.
- in_ready = (state==IDLE) | (state==VALID & out_ready). It is 0 in WAIT.
- Accept = in_valid & in_ready. On accept the bundle is registered.
  - Non-M op, or M op with latency L=1: next state is VALID, so out_valid rises the cycle after accept.
  - M op with L>1 (L = MUL_CYCLES or DIV_CYCLES): counter loads L-1 and next state is WAIT.
- WAIT: counter decrements each cycle. out_valid=0, busy=1. When the counter is 1, next state is VALID. out_valid therefore rises L cycles after accept.
- VALID with out_ready=0: hold the bundle stable; no accept.
- VALID with out_ready=1 and in_valid=1: back-to-back; the new bundle replaces the old with no bubble.
- VALID with out_ready=1 and in_valid=0: go to IDLE; out_valid=0.
- flush=1 (sync): next state IDLE, out_valid=0, counter=0. flush beats a same-cycle accept: in_ready is still driven but the accepted word is discarded.
- Decode fields are don't-care while out_valid=0, but they hold their last value (no combinational leak from instr).
- Reset mid-WAIT: immediate return to the reset state.

Optional Feature:
CU_ILLEGAL_DETECT_EN.
- Defined:
  - illegal=1 with the bundle when the opcode matches none of the eight classes, or when R-type funct7 is not in {0000000, 0100000, 0000001}.
  - An illegal bundle forces reg_write=0 and m_type=0 and takes the 1-cycle path.
- Undefined: the illegal port is absent; unmatched opcodes decode with all type flags 0 and imm_sel=5.

Test Plan:
- Reset release, then add x3,x1,x2 (0x002081B3) with in_valid=1, out_ready=1 -> next cycle out_valid=1, r_type=1, reg_write=1, rd=3, rs1=1, rs2=2, imm_sel=5, m_type=0.
- lw x4,8(x2) (0x00812203) -> load_type=1, size=3, imm_sel=0, reg_write=1. Follow it with addi x0,x0,0 (0x00000013) back-to-back -> i_type=1, reg_write=0, no bubble between the two out_valid beats.
- div x5,x6,x7 (0x027342B3), DIV_CYCLES=32 -> in_ready=0 and busy=1 for 31 cycles, out_valid rises exactly 32 cycles after accept with m_div=1. mul (0x027302B3) with MUL_CYCLES=1 -> out_valid the next cycle, m_type=1, m_div=0.
- Hold out_ready=0 for 5 cycles in VALID -> bundle stable, in_ready=0. Raising out_ready with in_valid=0 -> IDLE, out_valid=0.
- Assert flush 10 cycles into a div WAIT, with in_valid=1 the same cycle -> next cycle IDLE, out_valid=0, busy=0, nothing captured. Drop rst_n mid-WAIT -> all outputs 0 immediately.
- With CU_ILLEGAL_DETECT_EN, send 0x0000007F -> illegal=1, reg_write=0. Send R-type with funct7=0000010 -> illegal=1.
